// File: rtl/acc_cpu_param.sv
// acc_cpu_param: multi-cycle accumulator CPU with a parametrised address width.
// Instructions and data share one memory. The host writes that memory through
// the load port. Each instruction takes two cycles: one FETCH and one EXEC.
// Instruction word layout: {opcode[2:0], pad[], operand_address[ADDR_W-1:0]}.
module acc_cpu_param #(
  parameter  int ADDR_W = 5,
  localparam int DATA_W = ADDR_W + 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] Instruction,
  output logic [DATA_W-1:0] Acc,
  output logic [DATA_W-1:0] Mem,
  output logic [ADDR_W-1:0] Program_counter,
  output logic              halted,
  output logic              carry,
  output logic              zero
);

  localparam logic [1:0] S_HALT  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_EXEC  = 2'd3;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] ir_reg;
  logic [DATA_W-1:0] acc_reg;
  logic              carry_reg;

  // The memory has no reset, so its contents survive reset and HLT.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [2:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] mem_operand;
  logic [DATA_W:0]   sum;

  assign opcode      = ir_reg[DATA_W-1:DATA_W-3];
  assign operand     = ir_reg[ADDR_W-1:0];
  assign mem_operand = mem[operand];
  assign sum         = {1'b0, acc_reg} + {1'b0, mem_operand};

  assign Instruction     = ir_reg;
  assign Acc             = acc_reg;
  assign Mem             = mem_operand;
  assign Program_counter = pc_reg;
  assign halted          = (state_reg == S_HALT);
  assign carry           = carry_reg;
  assign zero            = (acc_reg == '0);

  // Controller and datapath registers. Reset takes priority over Load.
  // Load aborts the current fetch or execute step with no side effect.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_HALT;
      pc_reg    <= '0;
      ir_reg    <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
    end else if (Load) begin
      state_reg <= S_LOAD;
      if (state_reg == S_LOAD) begin
        pc_reg <= '0;
      end
    end else begin
      case (state_reg)
        S_HALT: state_reg <= S_HALT;
        S_LOAD: begin
          pc_reg    <= '0;
          state_reg <= S_FETCH;
        end
        S_FETCH: begin
          ir_reg    <= mem[pc_reg];
          pc_reg    <= pc_reg + 1'b1;
          state_reg <= S_EXEC;
        end
        default: begin
          state_reg <= S_FETCH;
          case (opcode)
            OP_HLT: state_reg <= S_HALT;
            OP_SKZ: if (acc_reg == '0) pc_reg <= pc_reg + 1'b1;
            OP_ADD: {carry_reg, acc_reg} <= sum;
            OP_AND: acc_reg <= acc_reg & mem_operand;
            OP_XOR: acc_reg <= acc_reg ^ mem_operand;
            OP_LDA: acc_reg <= mem_operand;
            OP_JMP: pc_reg <= operand;
            default: ;
          endcase
        end
      endcase
    end
  end

  // Memory writes. A host load has priority over STO.
  // A STO that Load aborts performs no write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (Load) begin
        mem[load_addr] <= data_in;
      end else if (state_reg == S_EXEC && opcode == OP_STO) begin
        mem[operand] <= acc_reg;
      end
    end
  end

endmodule

// File: tb/tb_acc_cpu_param.sv
// Testbench for acc_cpu_param. It applies table-driven single-operation
// programs and hand-written multi-cycle sequences. It also runs a
// second instance with ADDR_W=7.
module tb_acc_cpu_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       Load  = 1'b0;
  logic [4:0] load_addr = '0;
  logic [7:0] data_in   = '0;
  logic [7:0] Instruction, Acc, Mem;
  logic [4:0] Program_counter;
  logic       halted, carry, zero;

  logic       load7 = 1'b0;
  logic [6:0] load_addr7 = '0;
  logic [9:0] data_in7   = '0;
  logic [9:0] instruction7, acc7, mem7;
  logic [6:0] pc7;
  logic       halted7, carry7, zero7;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  acc_cpu_param #(.ADDR_W(5)) dut (
    .clock(clock), .reset(reset), .Load(Load), .load_addr(load_addr),
    .data_in(data_in), .Instruction(Instruction), .Acc(Acc), .Mem(Mem),
    .Program_counter(Program_counter), .halted(halted), .carry(carry),
    .zero(zero)
  );

  acc_cpu_param #(.ADDR_W(7)) dut7 (
    .clock(clock), .reset(reset), .Load(load7), .load_addr(load_addr7),
    .data_in(data_in7), .Instruction(instruction7), .Acc(acc7), .Mem(mem7),
    .Program_counter(pc7), .halted(halted7), .carry(carry7), .zero(zero7)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_acc;
    logic       exp_carry;
    logic [4:0] exp_pc;
    logic [7:0] exp_mem;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    Load  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [4:0] addr, input logic [7:0] data);
    load_addr = addr;
    data_in   = data;
    Load      = 1'b1;
    tick();
  endtask

  // Releases Load and counts rising edges until halted is seen.
  // The count is bounded by budget.
  task automatic run_to_halt(input int budget, output int cycles);
    Load   = 1'b0;
    cycles = 0;
    do begin
      @(posedge clock);
      cycles++;
      @(negedge clock);
    end while (!halted && cycles < budget);
  endtask

  initial begin
    int cyc;

    //          op      a      b      acc    c     pc     mem[0x11]
    vecs[0] = '{3'b010, 8'hF0, 8'h20, 8'h10, 1'b1, 5'h03, 8'h20}; // ADD wrap
    vecs[1] = '{3'b010, 8'h05, 8'h07, 8'h0C, 1'b0, 5'h03, 8'h07}; // ADD
    vecs[2] = '{3'b011, 8'hCA, 8'h0F, 8'h0A, 1'b0, 5'h03, 8'h0F}; // AND
    vecs[3] = '{3'b100, 8'hFF, 8'h0F, 8'hF0, 1'b0, 5'h03, 8'h0F}; // XOR
    vecs[4] = '{3'b101, 8'h12, 8'h34, 8'h34, 1'b0, 5'h03, 8'h34}; // LDA
    vecs[5] = '{3'b110, 8'h5A, 8'h00, 8'h5A, 1'b0, 5'h03, 8'h5A}; // STO
    vecs[6] = '{3'b001, 8'h00, 8'h77, 8'h00, 1'b0, 5'h04, 8'h77}; // SKZ taken
    vecs[7] = '{3'b001, 8'h01, 8'h77, 8'h01, 1'b0, 5'h03, 8'h77}; // SKZ not taken
    vecs[8] = '{3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 5'h03, 8'h01}; // ADD to zero

    // Reset has priority over Load. The 0xFF offered during reset must not be written.
    do_reset();
    load_word(5'h00, 8'h00);
    reset = 1'b1; Load = 1'b1; load_addr = 5'h00; data_in = 8'hFF;
    tick();
    reset = 1'b0; Load = 1'b0;
    @(negedge clock);
    chk("rst_halted", halted, 1'b1);
    chk("rst_pc", Program_counter, 5'h00);
    chk("rst_acc", Acc, 8'h00);
    chk("rst_carry", carry, 1'b0);
    chk("rst_zero", zero, 1'b1);
    chk("rst_ir", Instruction, 8'h00);
    load_word(5'h05, 8'h00);
    run_to_halt(20, cyc);
    chk("rst_mem0_kept_ir", Instruction, 8'h00);
    chk("rst_mem0_kept_cycles", cyc, 3);

    // Table program: LDA 0x10; <op> 0x11; HLT 0x11; HLT 0x11.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      load_word(5'h00, 8'hB0);
      load_word(5'h01, {vecs[i].op, 5'h11});
      load_word(5'h02, 8'h11);
      load_word(5'h03, 8'h11);
      load_word(5'h10, vecs[i].a);
      load_word(5'h11, vecs[i].b);
      run_to_halt(40, cyc);
      chk($sformatf("v%0d_halted", i), halted, 1'b1);
      chk($sformatf("v%0d_cycles", i), cyc, 7);
      chk($sformatf("v%0d_acc", i), Acc, vecs[i].exp_acc);
      chk($sformatf("v%0d_carry", i), carry, vecs[i].exp_carry);
      chk($sformatf("v%0d_zero", i), zero, vecs[i].exp_acc == 8'h00);
      chk($sformatf("v%0d_pc", i), Program_counter, vecs[i].exp_pc);
      chk($sformatf("v%0d_mem", i), Mem, vecs[i].exp_mem);
    end

    // After ADD sets carry, AND must leave carry unchanged.
    do_reset();
    load_word(5'h00, 8'hB0);
    load_word(5'h01, 8'h51);
    load_word(5'h02, 8'h72);
    load_word(5'h03, 8'h12);
    load_word(5'h10, 8'hF0);
    load_word(5'h11, 8'h20);
    load_word(5'h12, 8'hFF);
    run_to_halt(40, cyc);
    chk("addand_cycles", cyc, 9);
    chk("addand_acc", Acc, 8'h10);
    chk("addand_carry", carry, 1'b1);
    chk("addand_mem", Mem, 8'hFF);

    // SKZ at the last address with Acc=0: the PC wraps from 0x1F to 0x01.
    do_reset();
    load_word(5'h00, 8'hFF);
    load_word(5'h1F, 8'h20);
    load_word(5'h01, 8'h00);
    Load = 1'b0;
    repeat (5) tick();
    @(negedge clock);
    chk("skzwrap_ir", Instruction, 8'h20);
    chk("skzwrap_pc", Program_counter, 5'h01);
    run_to_halt(20, cyc);
    chk("skzwrap_halt_pc", Program_counter, 5'h02);
    chk("skzwrap_halted", halted, 1'b1);

    // Load is raised during the EXEC of a STO. The target word and Acc must be unchanged.
    do_reset();
    load_word(5'h00, 8'hB0);
    load_word(5'h01, 8'hD1);
    load_word(5'h02, 8'h11);
    load_word(5'h10, 8'h33);
    load_word(5'h11, 8'h44);
    Load = 1'b0;
    repeat (4) tick();
    load_word(5'h00, 8'h11);
    Load = 1'b0;
    @(negedge clock);
    chk("abort_acc", Acc, 8'h33);
    chk("abort_pc", Program_counter, 5'h02);
    chk("abort_halted", halted, 1'b0);
    tick();
    @(negedge clock);
    chk("restart_pc", Program_counter, 5'h00);
    chk("restart_halted", halted, 1'b0);
    run_to_halt(20, cyc);
    chk("restart_ir", Instruction, 8'h11);
    chk("abort_target_kept", Mem, 8'h44);
    chk("restart_end_pc", Program_counter, 5'h01);

    // Fibonacci program.
    do_reset();
    load_word(5'h00, 8'hE3);
    load_word(5'h03, 8'hBB); load_word(5'h04, 8'hDC); load_word(5'h05, 8'h5A);
    load_word(5'h06, 8'hDB); load_word(5'h07, 8'hBC); load_word(5'h08, 8'hDA);
    load_word(5'h09, 8'h9D); load_word(5'h0A, 8'h20); load_word(5'h0B, 8'hE3);
    load_word(5'h0C, 8'h00);
    load_word(5'h1A, 8'h01); load_word(5'h1B, 8'h00); load_word(5'h1C, 8'h00);
    load_word(5'h1D, 8'h90); load_word(5'h1E, 8'h00); load_word(5'h1F, 8'h01);
    run_to_halt(4000, cyc);
    chk("fib_halted", halted, 1'b1);
    chk("fib_pc", Program_counter, 5'h0D);
    chk("fib_acc", Acc, 8'h00);
    // Read the results back through the HLT operand. Memory survives Load and HLT.
    load_word(5'h00, 8'h1B);
    run_to_halt(20, cyc);
    chk("fib_mem1b", Mem, 8'd233);
    load_word(5'h00, 8'h1A);
    run_to_halt(20, cyc);
    chk("fib_mem1a", Mem, 8'd144);

    // ADDR_W=7 instance: JMP 0x7F, then HLT at 0x7F. The PC wraps to 0.
    do_reset();
    load_addr7 = 7'h00; data_in7 = 10'h3FF; load7 = 1'b1;
    tick();
    load_addr7 = 7'h7F; data_in7 = 10'h000;
    tick();
    load7 = 1'b0;
    cyc = 0;
    do begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
    end while (!halted7 && cyc < 40);
    chk("w7_halted", halted7, 1'b1);
    chk("w7_cycles", cyc, 5);
    chk("w7_pc", pc7, 7'h00);
    chk("w7_ir", instruction7, 10'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
